exp_bias_adder: RTL
===================

EXP_BIAS_ADDER -- requirements
Module: exp_bias_adder

Interface
REQ-001 Parameter EW, default 5, exponent field width in bits.
REQ-002 Parameter BIAS, default 15, exponent bias (2^(EW-1)-1).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand pair ea/eb valid.
REQ-006 in_ready  output  1  block accepts the operand pair this cycle.
REQ-007 ea  input  EW  biased exponent of operand A.
REQ-008 eb  input  EW  biased exponent of operand B.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 exp_out  output  EW  biased product exponent.
REQ-012 ovf  output  1  product exponent overflow (saturated to all-ones).
REQ-013 unf  output  1  product exponent underflow (flushed to zero).
REQ-014 zero  output  1  at least one operand exponent is 0.
REQ-015 spec  output  1  at least one operand exponent is all-ones (inf/NaN).
REQ-016 nv  output  1  invalid combination: zero and spec both set.

Function
REQ-017 The block is the additive counterpart of the team's exponent subtractor: it computes ea+eb-BIAS for the multiplier exponent path.
REQ-018 Two-stage pipeline: S1 registers sum=ea+eb (EW+1 bits, no loss) and the zero/spec operand flags; S2 registers res=sum-BIAS (EW+2-bit signed) and the final classification.
REQ-019 Handshake: a transfer occurs on a cycle where valid and ready are both high; in_ready = !s1_valid || s1 advances this cycle; S1 advances when !s2_valid || (out_valid && out_ready).
REQ-020 Latency: a pair accepted in cycle N produces out_valid in cycle N+2 when no backpressure occurs; throughput is one result per cycle.
REQ-021 While out_valid=1 and out_ready=0, exp_out and all flags hold stable and no stage overwrites a held result.
REQ-022 in_ready is a function of registered state and out_ready only, with no combinational path from in_valid.
REQ-023 Classification priority, highest first: spec -> exp_out = all-ones, ovf=0, unf=0; zero -> exp_out=0; res >= 2^EW-1 -> exp_out = all-ones, ovf=1; res <= 0 -> exp_out=0, unf=1; otherwise exp_out = res[EW-1:0].
REQ-024 nv=1 only when spec and zero are both set, in which case exp_out = all-ones.
REQ-025 Simultaneous accept and emit in one cycle is supported with no bubble and no loss.
REQ-026 Outputs are undefined-free: when out_valid=0, exp_out and all flags read 0.

Reset
REQ-027 On rst_n low, asynchronously: s1_valid=0, s2_valid=0, out_valid=0, exp_out=0, ovf=unf=zero=spec=nv=0.
REQ-028 While rst_n is low, in_ready=0; it becomes 1 in the first cycle after rst_n deasserts.
REQ-029 Reset asserted mid-operation discards all in-flight pairs; no result from before reset ever appears after reset.

Verification
REQ-030 ea=16, eb=16, out_ready=1 -> two cycles later: exp_out=17, all flags 0.
REQ-031 ea=30, eb=20 -> exp_out=31, ovf=1. ea=5, eb=6 -> exp_out=0, unf=1. ea=8, eb=7 -> exp_out=0, unf=1 (res=0 boundary).
REQ-032 ea=0, eb=20 -> zero=1, exp_out=0. ea=31, eb=0 -> spec=1, zero=1, nv=1, exp_out=31.
REQ-033 Stream 4 back-to-back pairs with out_ready=0 for 4 cycles -> in_ready drops after 2 accepts and outputs stay stable; releasing out_ready delivers all 4 results in order, one per cycle.
REQ-034 Assert rst_n low with both stages full -> out_valid=0 immediately; after release, the next accepted pair (ea=20, eb=15, result exp_out=20) is the first output seen.

Source files
------------

// File: rtl/exp_bias_adder.sv
// Two-stage product-exponent adder: exp_out = ea + eb - BIAS with saturation,
// flush-to-zero and zero/inf/NaN operand classification.
module exp_bias_adder #(
    parameter int unsigned EW   = 5,
    parameter int unsigned BIAS = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [EW-1:0] ea,
    input  logic [EW-1:0] eb,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [EW-1:0] exp_out,
    output logic          ovf,
    output logic          unf,
    output logic          zero,
    output logic          spec,
    output logic          nv
);

    localparam int unsigned SW = EW + 1;
    localparam int unsigned RW = EW + 2;
    localparam logic [EW-1:0]        ONES    = '1;
    localparam logic signed [RW-1:0] RES_MAX = RW'((2 ** EW) - 1);

    logic          run;
    logic          s1_valid;
    logic [SW-1:0] s1_sum;
    logic          s1_zero;
    logic          s1_spec;
    logic          s1_adv;

    logic signed [RW-1:0] res_c;
    logic [EW-1:0]        exp_c;
    logic                 ovf_c;
    logic                 unf_c;
    logic                 nv_c;

    // S1 may move into S2 whenever S2 is empty or its result leaves this cycle
    assign s1_adv   = !out_valid || (out_valid && out_ready);
    assign in_ready = run && (!s1_valid || s1_adv);
    assign res_c    = $signed(RW'(s1_sum) - RW'(BIAS));

    // Priority classification of the S1 sum; spec beats zero beats range checks
    always_comb begin
        exp_c = '0;
        ovf_c = 1'b0;
        unf_c = 1'b0;
        nv_c  = 1'b0;
        if (s1_spec) begin
            exp_c = ONES;
            nv_c  = s1_zero;
        end else if (s1_zero) begin
            exp_c = '0;
        end else if (res_c >= RES_MAX) begin
            exp_c = ONES;
            ovf_c = 1'b1;
        end else if (res_c[RW-1] || (res_c == '0)) begin
            exp_c = '0;
            unf_c = 1'b1;
        end else begin
            exp_c = res_c[EW-1:0];
        end
    end

    // run holds in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run      <= 1'b0;
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_zero  <= 1'b0;
            s1_spec  <= 1'b0;
        end else begin
            run <= 1'b1;
            if (in_ready) begin
                s1_valid <= in_valid;
                s1_sum   <= SW'(ea) + SW'(eb);
                s1_zero  <= (ea == '0) || (eb == '0);
                s1_spec  <= (ea == ONES) || (eb == ONES);
            end
        end
    end

    // S2 loads a result or a zeroed bubble; it holds while stalled downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            exp_out   <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            zero      <= 1'b0;
            spec      <= 1'b0;
            nv        <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= s1_valid;
            exp_out   <= s1_valid ? exp_c : '0;
            ovf       <= s1_valid && ovf_c;
            unf       <= s1_valid && unf_c;
            zero      <= s1_valid && s1_zero;
            spec      <= s1_valid && s1_spec;
            nv        <= s1_valid && nv_c;
        end
    end

endmodule
